// File: rtl/ssrelay_axil_regbank.sv
// AXI4-Lite register bank: NUM_REGS-NUM_RO RW control words plus NUM_RO read-only status words.
// Define SSRELAY_IRQ_EN to make the first status word sticky and add the irq output.
module ssrelay_axil_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int NUM_REGS           = 8,
   parameter int NUM_RO             = 2
) (
   input  logic                                         ACLK,
   input  logic                                         ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
   input  logic [2:0]                                   S_AXI_AWPROT,
   input  logic                                         S_AXI_AWVALID,
   output logic                                         S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
   input  logic                                         S_AXI_WVALID,
   output logic                                         S_AXI_WREADY,
   output logic [1:0]                                   S_AXI_BRESP,
   output logic                                         S_AXI_BVALID,
   input  logic                                         S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
   input  logic [2:0]                                   S_AXI_ARPROT,
   input  logic                                         S_AXI_ARVALID,
   output logic                                         S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
   output logic [1:0]                                   S_AXI_RRESP,
   output logic                                         S_AXI_RVALID,
   input  logic                                         S_AXI_RREADY,
   output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
   input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]         status_in,
   output logic [NUM_REGS-NUM_RO-1:0]                   wr_pulse
`ifdef SSRELAY_IRQ_EN
   ,
   output logic                                         irq
`endif
);
   localparam int DW       = C_S_AXI_DATA_WIDTH;
   localparam int AW       = C_S_AXI_ADDR_WIDTH;
   localparam int NB       = DW / 8;
   localparam int NUM_RW   = NUM_REGS - NUM_RO;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam int TOP      = ADDR_LSB + IDX_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_COMMIT, W_RESP} wstate_t;

   wstate_t             wstate_q, wstate_d;
   logic                awready_q, awready_d, wready_q, wready_d;
   logic [AW-1:0]       awaddr_q, awaddr_d;
   logic [DW-1:0]       wdata_q, wdata_d;
   logic [NB-1:0]       wstrb_q, wstrb_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
   logic [NUM_RW*DW-1:0] ctrl_q, ctrl_d;
   logic [NUM_RW-1:0]   wr_pulse_q, wr_pulse_d;
   logic                arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
   logic                rd_bad_q, rd_bad_d;
   logic [DW-1:0]       word [NUM_REGS];
   logic                aw_hs, w_hs, ar_hs, w_err, r_bad;
   logic [IDX_W-1:0]    w_idx, r_idx;
   logic [DW-1:0]       r_word;

   // Any address bit above the register index makes the access out of range.
   function automatic logic addr_bad(input logic [AW-1:0] a);
      return (a >> TOP) != {AW{1'b0}};
   endfunction

   assign aw_hs = S_AXI_AWVALID & awready_q;
   assign w_hs  = S_AXI_WVALID & wready_q;
   assign ar_hs = S_AXI_ARVALID & arready_q;
   assign w_idx = awaddr_q[ADDR_LSB +: IDX_W];
   assign w_err = addr_bad(awaddr_q) || (int'(w_idx) >= NUM_RW);
   assign r_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
   assign r_bad = addr_bad(S_AXI_ARADDR);

`ifdef SSRELAY_IRQ_EN
   logic [DW-1:0] sticky_q, sticky_d;
   logic          irq_q, irq_d, r_clr;

   assign r_clr = rvalid_q & S_AXI_RREADY & ~rd_bad_q & (rd_idx_q == IDX_W'(NUM_RW));

   // A new status bit in the same cycle as the clearing read survives.
   always_comb begin
      sticky_d = (sticky_q & ~{DW{r_clr}}) | status_in[DW-1:0];
      irq_d    = |(sticky_q & ctrl_q[DW-1:0]);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         sticky_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
         if (gi < NUM_RW) begin : g_rw
            assign word[gi] = ctrl_q[gi*DW +: DW];
`ifdef SSRELAY_IRQ_EN
         end else if (gi == NUM_RW) begin : g_sticky
            assign word[gi] = sticky_q;
`endif
         end else begin : g_ro
            assign word[gi] = status_in[(gi-NUM_RW)*DW +: DW];
         end
      end
   endgenerate

   always_comb begin
      r_word = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(r_idx) == i) r_word = word[i];
   end

   always_comb begin
      wstate_d   = wstate_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      awaddr_d   = aw_hs ? S_AXI_AWADDR : awaddr_q;
      wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
      wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      ctrl_d     = ctrl_q;
      wr_pulse_d = '0;
      case (wstate_q)
         W_IDLE: begin
            awready_d = ~aw_hs;
            wready_d  = ~w_hs;
            if (aw_hs && w_hs) wstate_d = W_COMMIT;
            else if (aw_hs)    wstate_d = W_GOT_AW;
            else if (w_hs)     wstate_d = W_GOT_W;
         end
         W_GOT_AW: if (w_hs) begin
            wready_d = 1'b0;
            wstate_d = W_COMMIT;
         end
         W_GOT_W: if (aw_hs) begin
            awready_d = 1'b0;
            wstate_d  = W_COMMIT;
         end
         W_COMMIT: begin
            bvalid_d = 1'b1;
            bresp_d  = w_err ? RESP_SLVERR : RESP_OKAY;
            for (int i = 0; i < NUM_RW; i++) begin
               if (!w_err && w_idx == IDX_W'(i)) begin
                  wr_pulse_d[i] = 1'b1;
                  for (int b = 0; b < NB; b++)
                     if (wstrb_q[b]) ctrl_d[i*DW + b*8 +: 8] = wdata_q[b*8 +: 8];
               end
            end
            wstate_d = W_RESP;
         end
         W_RESP: if (S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
            wstate_d  = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Read data is captured from pre-commit contents at the AR handshake edge.
   always_comb begin
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rd_idx_d  = rd_idx_q;
      rd_bad_d  = rd_bad_q;
      if (ar_hs) begin
         arready_d = 1'b0;
         rvalid_d  = 1'b1;
         rdata_d   = r_bad ? '0 : r_word;
         rresp_d   = r_bad ? RESP_SLVERR : RESP_OKAY;
         rd_idx_d  = r_idx;
         rd_bad_d  = r_bad;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d  = 1'b0;
         arready_d = 1'b1;
      end else if (!rvalid_q) begin
         arready_d = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate_q   <= W_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         ctrl_q     <= '0;
         wr_pulse_q <= '0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rd_idx_q   <= '0;
         rd_bad_q   <= 1'b0;
      end else begin
         wstate_q   <= wstate_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         ctrl_q     <= ctrl_d;
         wr_pulse_q <= wr_pulse_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rd_idx_q   <= rd_idx_d;
         rd_bad_q   <= rd_bad_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, awaddr_q, rd_idx_q, rd_bad_q};

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign ctrl_out      = ctrl_q;
   assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_ssrelay_axil_regbank.sv
// Scoreboard bench for ssrelay_axil_regbank (DW=32, 8 regs, 2 RO); irq checks only with SSRELAY_IRQ_EN.
module tb_ssrelay_axil_regbank;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   awaddr, araddr;
   logic [2:0]   awprot, arprot;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [191:0] ctrl_out;
   logic [63:0]  status_in;
   logic [5:0]   wr_pulse;
`ifdef SSRELAY_IRQ_EN
   logic         irq;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   int          pulse_cnt [6];
   logic [1:0]  exp_b [$];
   logic [33:0] exp_r [$];

   always #5 clk = ~clk;

   ssrelay_axil_regbank dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse)
`ifdef SSRELAY_IRQ_EN
      , .irq(irq)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no handshake, required one within the cycle budget", name);
   endtask

   // Pops the expected response whenever the DUT completes a B or R handshake.
   task automatic monitor();
      logic [33:0] e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 6; i++) if (wr_pulse[i]) pulse_cnt[i]++;
         if (bvalid && bready) begin
            $display("B resp=%b", bresp);
            if (exp_b.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL b_unexpected: got resp %b, required no B response", bresp);
            end else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
         end
         if (rvalid && rready) begin
            $display("R data=0x%08h resp=%b", rdata, rresp);
            if (exp_r.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL r_unexpected: got data 0x%0h, required no R response", rdata);
            end else begin
               e = exp_r.pop_front();
               check("rdata", 64'(rdata), 64'(e[31:0]));
               check("rresp", 64'(rresp), 64'(e[33:32]));
            end
         end
      end
   endtask

   task automatic wait_b();
      int c = 0;
      @(negedge clk);
      while (!(bvalid && bready) && c < 40) begin @(negedge clk); c++; end
      if (!(bvalid && bready)) timeout_fail("b_wait");
      @(posedge clk); #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
      bit aw_done, w_done;
      int c = 0;
      exp_b.push_back(r);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while ((awvalid || wvalid) && c < 40) begin
         @(negedge clk);
         aw_done = awvalid && awready;
         w_done  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_done) awvalid = 1'b0;
         if (w_done) wvalid = 1'b0;
         c++;
      end
      if (awvalid || wvalid) begin
         timeout_fail("write_addr_data");
         awvalid = 1'b0; wvalid = 1'b0;
         void'(exp_b.pop_back());
      end else wait_b();
   endtask

   task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
      bit done = 1'b0;
      int c = 0;
      exp_r.push_back({r, d});
      araddr = a; arvalid = 1'b1;
      while (!done && c < 40) begin
         @(negedge clk);
         done = arready;
         @(posedge clk); #1;
         c++;
      end
      arvalid = 1'b0;
      if (!done) begin
         timeout_fail("read_addr");
         void'(exp_r.pop_back());
      end else begin
         c = 0;
         @(negedge clk);
         while (!(rvalid && rready) && c < 40) begin @(negedge clk); c++; end
         if (!(rvalid && rready)) timeout_fail("r_wait");
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int pc, c;
      bit hs;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      status_in = {32'h5A5A_0007, 32'h0000_0000};
      foreach (pulse_cnt[i]) pulse_cnt[i] = 0;
      fork monitor(); join_none

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 64'(awready), 0);
      check("rst_wready", 64'(wready), 0);
      check("rst_arready", 64'(arready), 0);
      check("rst_bvalid", 64'(bvalid), 0);
      check("rst_rvalid", 64'(rvalid), 0);
      check("rst_ctrl", 64'(|ctrl_out), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("awready_before_edge", 64'(awready), 0);
      @(negedge clk);
      check("awready_after_edge", 64'(awready), 1);
      check("arready_after_edge", 64'(arready), 1);
      @(posedge clk); #1;

      // basic write/read-back
      for (int i = 0; i < 6; i++) do_write(8'(i*4), 32'(i+1), 4'hF, OKAY);
      for (int i = 0; i < 6; i++) do_read(8'(i*4), 32'(i+1), OKAY);
      for (int i = 0; i < 6; i++) check($sformatf("pulse_cnt%0d", i), 64'(pulse_cnt[i]), 1);
      check("ctrl_out_reg5", 64'(ctrl_out[5*32 +: 32]), 64'h6);

      // byte strobes: bytes 0 and 2 take new data
      do_write(8'h04, 32'h1122_3344, 4'hF, OKAY);
      do_write(8'h04, 32'hAABB_CCDD, 4'b0101, OKAY);
      do_read(8'h04, 32'h11BB_33DD, OKAY);
      pc = pulse_cnt[1];
      do_write(8'h04, 32'hFFFF_FFFF, 4'b0000, OKAY);
      check("strb0_pulse", 64'(pulse_cnt[1]), 64'(pc + 1));
      do_read(8'h07, 32'h11BB_33DD, OKAY);

      // W before AW, B back-pressure
      bready = 1'b0;
      pc = pulse_cnt[2];
      exp_b.push_back(OKAY);
      wdata = 32'hCAFE_BABE; wstrb = 4'hF; wvalid = 1'b1;
      hs = 1'b0; c = 0;
      while (!hs && c < 40) begin @(negedge clk); hs = wready; @(posedge clk); #1; c++; end
      wvalid = 1'b0;
      if (!hs) timeout_fail("t3_w");
      repeat (3) begin
         @(negedge clk);
         check("t3_wready_held", 64'(wready), 0);
         check("t3_awready_open", 64'(awready), 1);
      end
      @(posedge clk); #1;
      awaddr = 8'h08; awvalid = 1'b1;
      hs = 1'b0; c = 0;
      while (!hs && c < 40) begin @(negedge clk); hs = awready; @(posedge clk); #1; c++; end
      awvalid = 1'b0;
      if (!hs) timeout_fail("t3_aw");
      c = 0;
      @(negedge clk);
      while (!bvalid && c < 40) begin @(negedge clk); c++; end
      for (int k = 0; k < 5; k++) begin
         check("t3_bvalid_held", 64'(bvalid), 1);
         check("t3_awready_blocked", 64'(awready), 0);
         if (k < 4) @(negedge clk);
      end
      @(posedge clk); #1 bready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t3_bvalid_done", 64'(bvalid), 0);
      check("t3_awready_reopen", 64'(awready), 1);
      check("t3_one_pulse", 64'(pulse_cnt[2]), 64'(pc + 1));
      @(posedge clk); #1;
      do_read(8'h08, 32'hCAFE_BABE, OKAY);

      // RO and out-of-range decode
      pc = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
      do_write(8'h18, 32'h0000_DEAD, 4'hF, SLVERR);
      do_write(8'h40, 32'h0000_BEEF, 4'hF, SLVERR);
      check("err_no_pulse", 64'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5]), 64'(pc));
      do_read(8'h18, 32'h0000_0000, OKAY);
      do_read(8'h1C, 32'h5A5A_0007, OKAY);
      do_read(8'h40, 32'h0000_0000, SLVERR);
      do_read(8'h00, 32'h0000_0001, OKAY);

      // reset in the middle of a write
      awaddr = 8'h00; awvalid = 1'b1;
      hs = 1'b0; c = 0;
      while (!hs && c < 40) begin @(negedge clk); hs = awready; @(posedge clk); #1; c++; end
      awvalid = 1'b0;
      if (!hs) timeout_fail("t5_aw");
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_ctrl", 64'(|ctrl_out), 0);
      check("t5_rst_awready", 64'(awready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("t5_awready_before_edge", 64'(awready), 0);
      @(negedge clk);
      check("t5_awready_after_edge", 64'(awready), 1);
      repeat (4) begin @(negedge clk); check("t5_no_bvalid", 64'(bvalid), 0); end
      @(posedge clk); #1;
      do_read(8'h04, 32'h0000_0000, OKAY);

`ifdef SSRELAY_IRQ_EN
      do_write(8'h00, 32'h0000_0001, 4'hF, OKAY);
      status_in[0] = 1'b1;
      @(posedge clk); #1 status_in[0] = 1'b0;
      @(negedge clk);
      check("irq_not_yet", 64'(irq), 0);
      @(negedge clk);
      check("irq_set", 64'(irq), 1);
      repeat (3) @(negedge clk);
      check("irq_sticky", 64'(irq), 1);
      @(posedge clk); #1;
      do_read(8'h18, 32'h0000_0001, OKAY);
      @(negedge clk);
      check("irq_before_clear", 64'(irq), 1);
      @(negedge clk);
      check("irq_cleared", 64'(irq), 0);
`endif

      repeat (3) @(negedge clk);
      check("exp_b_drained", 64'(exp_b.size()), 0);
      check("exp_r_drained", 64'(exp_r.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

endmodule
